// File: rtl/hazard_pkg.sv
// Shared state encoding and constants for the pipeline hazard sequencer.
package hazard_pkg;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StLuStall = 2'd1,
        StMemWait = 2'd2
    } hz_state_e;

    localparam int unsigned REG_W_DEFAULT = 4;
    localparam int unsigned ZERO_REG_ID   = 0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the ID-stage sources and the ID/EX load destination.
module hazard_detect
    import hazard_pkg::*;
#(
    parameter int unsigned REG_W    = REG_W_DEFAULT,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_op1,
    input  logic [REG_W-1:0] id_op2,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic             idex_valid,
    input  logic             idex_is_load,
    input  logic [REG_W-1:0] idex_dst,
    output logic             lu_hit
);

    logic dst_is_zero;
    logic src_match;

    always_comb begin
        dst_is_zero = ZERO_REG && (idex_dst == REG_W'(ZERO_REG_ID));
        src_match   = (id_use1 && (id_op1 == idex_dst)) || (id_use2 && (id_op2 == idex_dst));
        lu_hit      = idex_valid && idex_is_load && id_valid && src_match && !dst_is_zero;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: load-use stall, taken-branch flush and data-memory wait.
// Define HAZARD_PERF_EN to build the stall/flush performance counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_W       = REG_W_DEFAULT,
    parameter int unsigned LU_CYCLES   = 1,
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 16,
    parameter bit          ZERO_REG    = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_op1,
    input  logic [REG_W-1:0] id_op2,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic             idex_valid,
    input  logic             idex_is_load,
    input  logic [REG_W-1:0] idex_dst,
    input  logic             ex_br_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_hold,
    output logic             mem_err,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned       WAIT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [1:0]        LU_INIT  = 2'(LU_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    hz_state_e         state_q, state_d;
    hz_state_e         ret_q, ret_d;
    logic [1:0]        bub_q, bub_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_q, err_d;
    logic              lu_hit;
    logic              mem_block;

    hazard_detect #(
        .REG_W    (REG_W),
        .ZERO_REG (ZERO_REG)
    ) u_detect (
        .id_valid     (id_valid),
        .id_op1       (id_op1),
        .id_op2       (id_op2),
        .id_use1      (id_use1),
        .id_use2      (id_use2),
        .idex_valid   (idex_valid),
        .idex_is_load (idex_is_load),
        .idex_dst     (idex_dst),
        .lu_hit       (lu_hit)
    );

    assign mem_block = mem_req && !mem_ready;

    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        bub_d       = bub_q;
        wait_d      = wait_q;
        err_d       = err_q;
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_hold   = 1'b0;

        unique case (state_q)
            StRun: begin
                if (mem_block) begin
                    pc_we     = 1'b0;
                    ifid_we   = 1'b0;
                    pipe_hold = 1'b1;
                    ret_d     = StRun;
                    state_d   = StMemWait;
                    wait_d    = WAIT_W'(1);
                end else if (ex_br_taken) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (lu_hit) begin
                    pc_we       = 1'b0;
                    ifid_we     = 1'b0;
                    idex_bubble = 1'b1;
                    bub_d       = LU_INIT;
                    if (LU_INIT != 2'd0) state_d = StLuStall;
                end
            end
            StLuStall: begin
                pc_we   = 1'b0;
                ifid_we = 1'b0;
                // A memory wait parks the remaining bubbles until the access completes.
                if (mem_block) begin
                    pipe_hold = 1'b1;
                    ret_d     = StLuStall;
                    state_d   = StMemWait;
                    wait_d    = WAIT_W'(1);
                end else begin
                    idex_bubble = 1'b1;
                    bub_d       = bub_q - 2'd1;
                    if (bub_q == 2'd1) state_d = StRun;
                end
            end
            StMemWait: begin
                pc_we     = 1'b0;
                ifid_we   = 1'b0;
                pipe_hold = 1'b1;
                // The completing cycle does not count as a further wait cycle.
                if (mem_ready) begin
                    state_d = ret_q;
                end else if (wait_q != WAIT_MAX) begin
                    wait_d = wait_q + 1'b1;
                    if (wait_d == WAIT_MAX) err_d = 1'b1;
                end
            end
            default: state_d = StRun;
        endcase

        if (rst) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            pipe_hold   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StRun;
            ret_q   <= StRun;
            bub_q   <= '0;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            bub_q   <= bub_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    assign state_o = state_q;
    assign mem_err = err_q;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;
    logic             br_accept;

    assign br_accept = (state_q == StRun) && !mem_block && ex_br_taken;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_we && (stall_q != '1)) stall_q <= stall_q + 1'b1;
            if (br_accept && (flush_q != '1)) flush_q <= flush_q + 1'b1;
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
